spec_pack_out: RTL
==================

Name: spec_pack_out

Overview:
- Return-path counterpart to the range-bin input buffer. That buffer splits a pulse into range bins, each zero-padded to NFFT points, and feeds them serially to the FFT.
- This block takes the serial 16-bit per-point result stream coming back from the FFT/power stage. It keeps the first KEEP_POINTS points of every NFFT-point frame and packs point pairs into 32-bit words.
- Packed words are buffered for the host-side reader, which drains them with a rd_en/out_valid handshake. The block also reports when all NUM_BINS frames of a pulse are captured.

Parameters:
- NFFT, 1024, points per incoming frame.
- KEEP_POINTS, 512, leading points kept per frame; must be even and ≤ NFFT.
- NUM_BINS, 8, frames (range bins) per pulse.
- ADDR_W, 11, buffer address width; depth = 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- clr  in  1  synchronous clear: empties buffer, zeroes counters, clears overflow
- data_in  in  16  serial result point
- data_valid  in  1  data_in valid this cycle; gaps allowed
- rd_en  in  1  host read request
- data_out  out  32  packed word; first point of pair in [31:16], second in [15:0]
- out_valid  out  1  data_out valid, one cycle after an accepted read
- empty  out  1  buffer holds no words
- full  out  1  buffer holds 2^ADDR_W words
- overflow  out  1  sticky flag; a packed word was dropped
- pulse_done  out  1  one-cycle pulse after the last point of frame NUM_BINS-1

Behaviour:
- Reset and clr values: data_out=0, out_valid=0, empty=1, full=0, overflow=0, pulse_done=0; state=COLLECT; all counters 0.
- Point counter pt_cnt (0..NFFT-1):
  - Advances only on data_valid and wraps to 0 after NFFT-1.
  - A wrap increments frame counter bin_cnt (0..NUM_BINS-1).
- Keep window: a point is kept iff pt_cnt < KEEP_POINTS.
  - Even kept points are latched into the high half of the pair register.
  - On each odd kept point, {hi, data_in} is written to the buffer.
- State machine:
  - COLLECT: accepts points as above. On a valid point with pt_cnt=NFFT-1 and bin_cnt=NUM_BINS-1 → DONE, and bin_cnt wraps to 0.
  - DONE: pulse_done=1 for exactly one cycle → COLLECT.
  - A data_valid point arriving in DONE is processed normally as pt 0 of the next pulse; nothing is lost.
- Buffer write: accepted iff !full. A write attempted while full is dropped and sets overflow. Counters still advance.
- Buffer read: accepted iff rd_en && !empty. data_out updates and out_valid=1 on the next cycle. rd_en while empty is ignored, out_valid=0, and data_out holds its last value.
- Simultaneous accepted read and write: occupancy unchanged; full/empty unchanged.
- full/empty are registered and exact: they reflect occupancy after the current cycle's operations.
- Pointers are ADDR_W bits and wrap naturally. Occupancy is tracked with an ADDR_W+1-bit count.
- Reset asserted mid-frame: partial pair discarded, all buffered data lost, all counters restart at 0.
- clr: same effect as reset, synchronous to clk; clr has priority over same-cycle reads and writes.
- Total pipeline latency from the second point of a pair to !empty: 2 cycles.

Optional Feature:
- Macro: SPEC_PACK_OUT_FRAME_TAG_EN.
- Defined: before the first word of every frame, the header word 32'hA5A5_0000 | {bin_cnt[7:0], pulse_cnt[7:0]} is written.
  - pulse_cnt is an 8-bit wrapping count of completed pulses, reset to 0.
  - The header is written on the cycle of the frame's pt 0. The pair register is independent of the header.
  - Header writes obey the full/overflow rules.
  - Each frame produces KEEP_POINTS/2+1 words.
- Undefined: no header words are written; pulse_cnt logic is absent.

Test Plan:
- Frame pack and drain: NFFT=16, KEEP_POINTS=4, NUM_BINS=2; stream data_in=0..15 twice with data_valid held → 4 words 0x00000001, 0x00020003, 0x00000001, 0x00020003; pulse_done high exactly once, one cycle after the 32nd point.
- Gapped input: same stream with data_valid toggling every other cycle → identical words and word count.
- Overflow: ADDR_W=2, no reads, feed 12 kept pairs → full=1 after 4 words, overflow=1; the first 4 words read back intact.
- Read/write concurrency: buffer at 3 words, read and write in the same cycle → occupancy stays 3; empty=0, full=0; out_valid pulses next cycle.
- Empty read and reset: rd_en while empty → out_valid stays 0. Assert rst mid-frame, then restart the stream at pt 0 → first word is 0x00000001.
- Tag build (SPEC_PACK_OUT_FRAME_TAG_EN): first pulse → words 0xA5A50000, 0x00000001, 0x00020003, 0xA5A50100, ...

Source files
------------

// File: rtl/spec_pack_out.sv
// Keeps the leading KEEP_POINTS of each NFFT-point result frame, packs point pairs into
// 32-bit words and buffers them for the host. Optional SPEC_PACK_OUT_FRAME_TAG_EN adds a per-frame header word.
module spec_pack_out #(
  parameter int NFFT        = 1024,
  parameter int KEEP_POINTS = 512,
  parameter int NUM_BINS    = 8,
  parameter int ADDR_W      = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic        rd_en,
  output logic [31:0] data_out,
  output logic        out_valid,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        pulse_done
);

  localparam int PT_W  = (NFFT > 1) ? $clog2(NFFT) : 1;
  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PT_W-1:0]   PT_LAST  = PT_W'(NFFT - 1);
  localparam logic [BIN_W-1:0]  BIN_LAST = BIN_W'(NUM_BINS - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {COLLECT, DONE} state_t;

  state_t            state_q, state_d;
  logic [PT_W-1:0]   pt_cnt;
  logic [BIN_W-1:0]  bin_cnt;
  logic              pt_last, bin_last, kept, hi_ld, pair_wr, pulse_end;
  logic [15:0]       hi_q;
  logic              vld_p0;
  logic [31:0]       word_p0;
  logic [31:0]       word_d;
  logic              wr_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_acc, rd_acc;
  logic [31:0]       mem [DEPTH];

  assign pt_last   = (pt_cnt == PT_LAST);
  assign bin_last  = (bin_cnt == BIN_LAST);
  assign kept      = (int'(pt_cnt) < KEEP_POINTS);
  assign hi_ld     = data_valid && kept && !pt_cnt[0];
  assign pair_wr   = data_valid && kept && pt_cnt[0];
  assign pulse_end = data_valid && pt_last && bin_last;

`ifdef SPEC_PACK_OUT_FRAME_TAG_EN
  logic [7:0] pulse_cnt;
  logic       hdr_wr;

  // pt 0 is always even, so a header never collides with a pair write
  assign hdr_wr = data_valid && (pt_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pulse_cnt <= '0;
    else if (clr)            pulse_cnt <= '0;
    else if (pulse_end)      pulse_cnt <= pulse_cnt + 8'd1;
  end

  always_comb begin
    wr_d   = pair_wr || hdr_wr;
    word_d = {hi_q, data_in};
    if (hdr_wr) word_d = 32'hA5A5_0000 | {16'h0000, 8'(bin_cnt), pulse_cnt};
  end
`else
  always_comb begin
    wr_d   = pair_wr;
    word_d = {hi_q, data_in};
  end
`endif

  // Frame/bin counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_cnt  <= '0;
      bin_cnt <= '0;
    end else if (clr) begin
      pt_cnt  <= '0;
      bin_cnt <= '0;
    end else if (data_valid) begin
      pt_cnt <= pt_last ? '0 : pt_cnt + PT_W'(1);
      if (pt_last) bin_cnt <= bin_last ? '0 : bin_cnt + BIN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state_q <= COLLECT;
    else if (clr) state_q <= COLLECT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pulse_done = 1'b0;
    case (state_q)
      COLLECT: if (pulse_end) state_d = DONE;
      DONE: begin
        pulse_done = 1'b1;
        state_d    = pulse_end ? DONE : COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hi_ld) hi_q <= data_in;
  end

  // Stage p0: packed word registered before it reaches the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_p0 <= 1'b0;
    else if (clr) vld_p0 <= 1'b0;
    else          vld_p0 <= wr_d;
  end

  always_ff @(posedge clk) begin
    word_p0 <= word_d;
  end

  // Stage p1: buffer write/read against registered full/empty
  assign wr_acc = vld_p0 && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + (ADDR_W + 1)'(1);
      2'b01:   cnt_d = cnt_q - (ADDR_W + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem[wr_ptr] <= word_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (vld_p0 && full) overflow <= 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        data_out <= mem[rd_ptr];
      end
      out_valid <= rd_acc;
      cnt_q     <= cnt_d;
      empty     <= (cnt_d == '0);
      full      <= (cnt_d == DEPTH_C);
    end
  end

endmodule
